// File: rtl/mem_request_arbiter_pkg.sv
// Shared constants and types for the three-way memory request arbiter.
package mem_request_arbiter_pkg;
   localparam logic TRUE       = 1'b1;
   localparam logic FALSE      = 1'b0;
   localparam logic READ_FLAG  = 1'b0;
   localparam logic WRITE_FLAG = 1'b1;
   localparam int   ADDR_W     = 32;
   localparam int   DATA_W     = 32;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   localparam data_t      ZERO_WORD = 32'h0000_0000;
   localparam logic [2:0] LEN_WORD  = 3'd4;

   typedef enum logic [1:0] {
      OWN_IF = 2'd0,
      OWN_LS = 2'd1,
      OWN_PF = 2'd2
   } arb_owner_e;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_BUSY  = 2'd2,
      ARB_DRAIN = 2'd3
   } arb_state_e;

   typedef struct packed {
      logic       we;
      addr_t      addr;
      data_t      wdata;
      logic [2:0] len;
   } mem_req_t;

   localparam mem_req_t REQ_NONE = '{we: READ_FLAG, addr: 32'h0000_0000,
                                     wdata: 32'h0000_0000, len: 3'd0};

   function automatic mem_req_t make_req(input logic we, input addr_t addr,
                                         input data_t wdata, input logic [2:0] len);
      mem_req_t r;
      r.we    = we;
      r.addr  = addr;
      r.wdata = wdata;
      r.len   = len;
      return r;
   endfunction

   function automatic logic is_store(input mem_req_t r);
      return r.we == WRITE_FLAG;
   endfunction
endpackage

// File: rtl/mem_request_arbiter_slot.sv
// One-entry request slot: captures a start pulse and holds it until granted or flushed.
// With keep_i set, a store (held or arriving) survives a flush.
module mem_req_slot
   import mem_request_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy_i,
   input  logic        wr_i,
   input  logic        clr_i,
   input  logic        flush_i,
   input  logic        keep_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  len_i,
   output logic        valid_o,
   output logic        we_o,
   output logic [31:0] addr_o,
   output logic [31:0] wdata_o,
   output logic [2:0]  len_o,
   output logic        ovf_o
);

   logic     valid_q, valid_d;
   mem_req_t req_q, req_d;
   logic     survive_s;
   logic     accept_s;

   // Flush and grant clear are resolved before the incoming pulse is considered.
   always_comb begin
      valid_d   = valid_q;
      req_d     = req_q;
      survive_s = valid_q & ~clr_i & ~(flush_i & ~(keep_i & is_store(req_q)));
      accept_s  = wr_i & (~flush_i | (keep_i & (we_i == WRITE_FLAG)));
      if (survive_s) begin
         valid_d = TRUE;
         req_d   = req_q;
      end else if (accept_s) begin
         valid_d = TRUE;
         req_d   = make_req(we_i, addr_i, wdata_i, len_i);
      end else begin
         valid_d = FALSE;
         req_d   = req_q;
      end
   end

   // Slot storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= FALSE;
         req_q   <= REQ_NONE;
      end else if (rdy_i) begin
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   assign ovf_o   = rdy_i & accept_s & survive_s;
   assign valid_o = valid_q;
   assign we_o    = req_q.we;
   assign addr_o  = req_q.addr;
   assign wdata_o = req_q.wdata;
   assign len_o   = req_q.len;

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates IF, LSU and prefetch requests onto a single memory controller port,
// one transaction at a time, with flush cancellation of speculative reads.
module mem_request_arbiter
   import mem_request_arbiter_pkg::*;
#(
   parameter int PRIO_PF_HOLD = 4,
   parameter int PERF_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              stop_signal,
   input  logic              if_req,
   input  logic [31:0]       if_pc,
   output logic              if_done,
   output logic [31:0]       if_inst,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [31:0]       ls_addr,
   input  logic [31:0]       ls_wdata,
   input  logic [2:0]        ls_len,
   output logic              ls_done,
   output logic [31:0]       ls_rdata,
   input  logic              pf_req,
   input  logic [31:0]       pf_addr,
   output logic              pf_done,
   output logic [31:0]       pf_data,
   output logic              mc_req,
   output logic              mc_we,
   output logic [31:0]       mc_addr,
   output logic [31:0]       mc_wdata,
   output logic [2:0]        mc_len,
   input  logic              mc_done,
   input  logic [31:0]       mc_rdata,
   output logic [PERF_W-1:0] busy_cycles,
   output logic              err_overflow
);

   localparam int             CNT_W    = $clog2(PRIO_PF_HOLD + 2);
   localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(PRIO_PF_HOLD);

   logic        if_v_s, if_we_s, if_ovf_s;
   logic [31:0] if_addr_s, if_wdata_s;
   logic [2:0]  if_len_s;
   logic        ls_v_s, ls_we_s, ls_ovf_s;
   logic [31:0] ls_addr_s, ls_wdata_s;
   logic [2:0]  ls_len_s;
   logic        pf_v_s, pf_we_s, pf_ovf_s;
   logic [31:0] pf_addr_s, pf_wdata_s;
   logic [2:0]  pf_len_s;

   logic        pick_if_s, pick_ls_s, pick_pf_s;
   mem_req_t    sel_s;
   arb_owner_e  sel_owner_s;
   logic        flush_cancel_s;

   arb_state_e        state_q;
   arb_owner_e        owner_q;
   logic              mc_req_q, mc_we_q;
   logic [31:0]       mc_addr_q, mc_wdata_q;
   logic [2:0]        mc_len_q;
   logic              if_done_q, ls_done_q, pf_done_q;
   logic [31:0]       if_inst_q, ls_rdata_q, pf_data_q;
   logic [PERF_W-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]  pf_cnt_q, pf_cnt_d;
   logic              err_q, err_d;

   mem_req_slot u_if_slot (
      .clk(clk), .rst(rst), .rdy_i(rdy), .wr_i(if_req), .clr_i(pick_if_s),
      .flush_i(stop_signal), .keep_i(FALSE), .we_i(READ_FLAG), .addr_i(if_pc),
      .wdata_i(ZERO_WORD), .len_i(LEN_WORD), .valid_o(if_v_s), .we_o(if_we_s),
      .addr_o(if_addr_s), .wdata_o(if_wdata_s), .len_o(if_len_s), .ovf_o(if_ovf_s)
   );

   mem_req_slot u_ls_slot (
      .clk(clk), .rst(rst), .rdy_i(rdy), .wr_i(ls_req), .clr_i(pick_ls_s),
      .flush_i(stop_signal), .keep_i(TRUE), .we_i(ls_we), .addr_i(ls_addr),
      .wdata_i(ls_wdata), .len_i(ls_len), .valid_o(ls_v_s), .we_o(ls_we_s),
      .addr_o(ls_addr_s), .wdata_o(ls_wdata_s), .len_o(ls_len_s), .ovf_o(ls_ovf_s)
   );

   mem_req_slot u_pf_slot (
      .clk(clk), .rst(rst), .rdy_i(rdy), .wr_i(pf_req), .clr_i(pick_pf_s),
      .flush_i(stop_signal), .keep_i(FALSE), .we_i(READ_FLAG), .addr_i(pf_addr),
      .wdata_i(ZERO_WORD), .len_i(LEN_WORD), .valid_o(pf_v_s), .we_o(pf_we_s),
      .addr_o(pf_addr_s), .wdata_o(pf_wdata_s), .len_o(pf_len_s), .ovf_o(pf_ovf_s)
   );

   // Fixed-priority pick in IDLE; a flush in the same cycle removes cancellable slots.
   always_comb begin
      pick_if_s   = FALSE;
      pick_ls_s   = FALSE;
      pick_pf_s   = FALSE;
      sel_s       = REQ_NONE;
      sel_owner_s = OWN_IF;
      if (state_q != ARB_IDLE) begin
         sel_s = REQ_NONE;
      end else if (ls_v_s && (!stop_signal || ls_we_s == WRITE_FLAG)) begin
         pick_ls_s   = TRUE;
         sel_owner_s = OWN_LS;
         sel_s       = make_req(ls_we_s, ls_addr_s, ls_wdata_s, ls_len_s);
      end else if (if_v_s && !stop_signal) begin
         pick_if_s   = TRUE;
         sel_owner_s = OWN_IF;
         sel_s       = make_req(if_we_s, if_addr_s, if_wdata_s, if_len_s);
      end else if (pf_v_s && !stop_signal && pf_cnt_q >= CNT_HOLD) begin
         pick_pf_s   = TRUE;
         sel_owner_s = OWN_PF;
         sel_s       = make_req(pf_we_s, pf_addr_s, pf_wdata_s, pf_len_s);
      end else begin
         sel_s = REQ_NONE;
      end
   end

   assign flush_cancel_s = stop_signal & ~(owner_q == OWN_LS && mc_we_q == WRITE_FLAG);

   // Performance counter, prefetch hold counter and sticky overflow flag.
   always_comb begin
      busy_d   = busy_q;
      pf_cnt_d = pf_cnt_q;
      err_d    = err_q | if_ovf_s | ls_ovf_s | pf_ovf_s;
      if (state_q == ARB_BUSY || state_q == ARB_DRAIN) begin
         busy_d = busy_q + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
         busy_d = busy_q;
      end
      if (state_q == ARB_IDLE && !if_v_s && !ls_v_s) begin
         if (pf_cnt_q < CNT_HOLD) begin
            pf_cnt_d = pf_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            pf_cnt_d = pf_cnt_q;
         end
      end else begin
         pf_cnt_d = {CNT_W{1'b0}};
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q   <= {PERF_W{1'b0}};
         pf_cnt_q <= {CNT_W{1'b0}};
         err_q    <= FALSE;
      end else if (rdy) begin
         busy_q   <= busy_d;
         pf_cnt_q <= pf_cnt_d;
         err_q    <= err_d;
      end
   end

   // Transaction FSM with registered controller and requester outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         owner_q    <= OWN_IF;
         mc_req_q   <= FALSE;
         mc_we_q    <= READ_FLAG;
         mc_addr_q  <= ZERO_WORD;
         mc_wdata_q <= ZERO_WORD;
         mc_len_q   <= 3'd0;
         if_done_q  <= FALSE;
         ls_done_q  <= FALSE;
         pf_done_q  <= FALSE;
         if_inst_q  <= ZERO_WORD;
         ls_rdata_q <= ZERO_WORD;
         pf_data_q  <= ZERO_WORD;
      end else if (rdy) begin
         mc_req_q  <= FALSE;
         if_done_q <= FALSE;
         ls_done_q <= FALSE;
         pf_done_q <= FALSE;
         case (state_q)
            ARB_IDLE: begin
               if (pick_if_s || pick_ls_s || pick_pf_s) begin
                  owner_q    <= sel_owner_s;
                  mc_req_q   <= TRUE;
                  mc_we_q    <= sel_s.we;
                  mc_addr_q  <= sel_s.addr;
                  mc_wdata_q <= sel_s.wdata;
                  mc_len_q   <= sel_s.len;
                  state_q    <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               state_q <= flush_cancel_s ? ARB_DRAIN : ARB_BUSY;
            end
            ARB_BUSY: begin
               if (mc_done) begin
                  state_q <= ARB_IDLE;
                  if (!flush_cancel_s) begin
                     case (owner_q)
                        OWN_IF: begin
                           if_done_q <= TRUE;
                           if_inst_q <= mc_rdata;
                        end
                        OWN_LS: begin
                           ls_done_q  <= TRUE;
                           ls_rdata_q <= mc_rdata;
                        end
                        OWN_PF: begin
                           pf_done_q <= TRUE;
                           pf_data_q <= mc_rdata;
                        end
                        default: begin
                           if_done_q <= FALSE;
                        end
                     endcase
                  end
               end else if (flush_cancel_s) begin
                  state_q <= ARB_DRAIN;
               end
            end
            ARB_DRAIN: begin
               if (mc_done) begin
                  state_q <= ARB_IDLE;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
            end
         endcase
      end
   end

   assign mc_req       = mc_req_q;
   assign mc_we        = mc_we_q;
   assign mc_addr      = mc_addr_q;
   assign mc_wdata     = mc_wdata_q;
   assign mc_len       = mc_len_q;
   assign if_done      = if_done_q;
   assign if_inst      = if_inst_q;
   assign ls_done      = ls_done_q;
   assign ls_rdata     = ls_rdata_q;
   assign pf_done      = pf_done_q;
   assign pf_data      = pf_data_q;
   assign busy_cycles  = busy_q;
   assign err_overflow = err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed self-checking bench for mem_request_arbiter; inputs driven and outputs sampled on negedge.
module tb_mem_request_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, stop_signal;
   logic        if_req, ls_req, ls_we, pf_req, mc_done;
   logic [31:0] if_pc, ls_addr, ls_wdata, pf_addr, mc_rdata;
   logic [2:0]  ls_len;
   logic        if_done, ls_done, pf_done, mc_req, mc_we, err_overflow;
   logic [31:0] if_inst, ls_rdata, pf_data, mc_addr, mc_wdata, busy_cycles;
   logic [2:0]  mc_len;
   int          total, bad;

   mem_request_arbiter #(.PRIO_PF_HOLD(4), .PERF_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .stop_signal(stop_signal),
      .if_req(if_req), .if_pc(if_pc), .if_done(if_done), .if_inst(if_inst),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_len(ls_len), .ls_done(ls_done), .ls_rdata(ls_rdata),
      .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done), .pf_data(pf_data),
      .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
      .mc_len(mc_len), .mc_done(mc_done), .mc_rdata(mc_rdata),
      .busy_cycles(busy_cycles), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      total++;
      if (mc_req !== 1'b0 || mc_we !== 1'b0 || mc_addr !== 32'h0 || mc_wdata !== 32'h0 || mc_len !== 3'd0) begin
         bad++;
         $display("FAIL reset_mc: req=%0b we=%0b addr=%h wdata=%h len=%0d want all 0", mc_req, mc_we, mc_addr, mc_wdata, mc_len);
      end
      total++;
      if (if_done !== 1'b0 || ls_done !== 1'b0 || pf_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_done: if=%0b ls=%0b pf=%0b want 0", if_done, ls_done, pf_done);
      end
      total++;
      if (if_inst !== 32'h0 || ls_rdata !== 32'h0 || pf_data !== 32'h0) begin
         bad++;
         $display("FAIL reset_data: if=%h ls=%h pf=%h want 0", if_inst, ls_rdata, pf_data);
      end
      total++;
      if (busy_cycles !== 32'h0 || err_overflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_perf: busy=%0d err=%0b want 0/0", busy_cycles, err_overflow);
      end
   endtask

   task automatic test_single_fetch();
      if_req = 1'b1; if_pc = 32'h100;
      step();
      if_req = 1'b0;
      total++;
      if (mc_req !== 1'b0) begin bad++; $display("FAIL fetch_early: mc_req=%0b want 0", mc_req); end
      step();
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h100 || mc_len !== 3'd4 || mc_we !== 1'b0) begin
         bad++;
         $display("FAIL fetch_issue: req=%0b addr=%h len=%0d we=%0b want 1/00000100/4/0", mc_req, mc_addr, mc_len, mc_we);
      end
      step();
      total++;
      if (mc_req !== 1'b0 || mc_addr !== 32'h100) begin
         bad++;
         $display("FAIL fetch_one_pulse: req=%0b addr=%h want 0/00000100", mc_req, mc_addr);
      end
      repeat (4) step();
      mc_done = 1'b1; mc_rdata = 32'h00A00093;
      step();
      mc_done = 1'b0;
      total++;
      if (if_done !== 1'b1 || if_inst !== 32'h00A00093) begin
         bad++;
         $display("FAIL fetch_done: done=%0b inst=%h want 1/00a00093", if_done, if_inst);
      end
      total++;
      if (busy_cycles !== 32'd5) begin bad++; $display("FAIL fetch_busy: busy=%0d want 5", busy_cycles); end
      step();
      total++;
      if (if_done !== 1'b0 || if_inst !== 32'h00A00093) begin
         bad++;
         $display("FAIL fetch_hold: done=%0b inst=%h want 0/00a00093", if_done, if_inst);
      end
   endtask

   task automatic test_simultaneous();
      if_req = 1'b1; if_pc = 32'h200;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h1000; ls_len = 3'd4;
      step();
      if_req = 1'b0; ls_req = 1'b0;
      step();
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h1000 || mc_we !== 1'b0 || mc_len !== 3'd4) begin
         bad++;
         $display("FAIL sim_ls_first: req=%0b addr=%h we=%0b len=%0d want 1/00001000/0/4", mc_req, mc_addr, mc_we, mc_len);
      end
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (mc_req !== 1'b0) begin bad++; $display("FAIL sim_overlap: mc_req=%0b want 0", mc_req); end
      end
      step();
      mc_done = 1'b1; mc_rdata = 32'hDEADBEEF;
      step();
      mc_done = 1'b0;
      total++;
      if (ls_done !== 1'b1 || ls_rdata !== 32'hDEADBEEF || if_done !== 1'b0 || mc_req !== 1'b0 || if_inst !== 32'h00A00093) begin
         bad++;
         $display("FAIL sim_ls_done: ls_done=%0b rdata=%h if_done=%0b mc_req=%0b inst=%h want 1/deadbeef/0/0/00a00093",
                  ls_done, ls_rdata, if_done, mc_req, if_inst);
      end
      step();
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h200 || ls_done !== 1'b0) begin
         bad++;
         $display("FAIL sim_if_next: req=%0b addr=%h ls_done=%0b want 1/00000200/0", mc_req, mc_addr, ls_done);
      end
      step();
      step();
      mc_done = 1'b1; mc_rdata = 32'h12345678;
      step();
      mc_done = 1'b0;
      total++;
      if (if_done !== 1'b1 || if_inst !== 32'h12345678 || ls_rdata !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL sim_if_done: done=%0b inst=%h ls_rdata=%h want 1/12345678/deadbeef", if_done, if_inst, ls_rdata);
      end
   endtask

   task automatic test_flush_fetch();
      if_req = 1'b1; if_pc = 32'h300;
      step();
      if_req = 1'b0;
      step();
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h300) begin
         bad++;
         $display("FAIL flush_issue: req=%0b addr=%h want 1/00000300", mc_req, mc_addr);
      end
      step();
      stop_signal = 1'b1;
      step();
      stop_signal = 1'b0;
      step();
      step();
      mc_done = 1'b1; mc_rdata = 32'h00000BAD;
      step();
      mc_done = 1'b0;
      total++;
      if (if_done !== 1'b0 || if_inst !== 32'h12345678 || mc_req !== 1'b0) begin
         bad++;
         $display("FAIL flush_drain: done=%0b inst=%h mc_req=%0b want 0/12345678/0", if_done, if_inst, mc_req);
      end
      if_req = 1'b1; if_pc = 32'h304;
      step();
      if_req = 1'b0;
      step();
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h304) begin
         bad++;
         $display("FAIL flush_resume: req=%0b addr=%h want 1/00000304", mc_req, mc_addr);
      end
      step();
      mc_done = 1'b1; mc_rdata = 32'h11111111;
      step();
      mc_done = 1'b0;
      total++;
      if (if_done !== 1'b1 || if_inst !== 32'h11111111) begin
         bad++;
         $display("FAIL flush_resume_done: done=%0b inst=%h want 1/11111111", if_done, if_inst);
      end
   endtask

   task automatic test_flush_store();
      logic seen;
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h30000; ls_wdata = 32'h41; ls_len = 3'd1;
      if_req = 1'b1; if_pc = 32'h400;
      step();
      ls_req = 1'b0; if_req = 1'b0; stop_signal = 1'b1;
      step();
      stop_signal = 1'b0;
      total++;
      if (mc_req !== 1'b1 || mc_we !== 1'b1 || mc_addr !== 32'h30000 || mc_wdata !== 32'h41 || mc_len !== 3'd1) begin
         bad++;
         $display("FAIL store_issue: req=%0b we=%0b addr=%h wdata=%h len=%0d want 1/1/00030000/00000041/1",
                  mc_req, mc_we, mc_addr, mc_wdata, mc_len);
      end
      step();
      stop_signal = 1'b1;
      step();
      stop_signal = 1'b0;
      mc_done = 1'b1; mc_rdata = 32'h0;
      step();
      mc_done = 1'b0;
      total++;
      if (ls_done !== 1'b1) begin bad++; $display("FAIL store_done: ls_done=%0b want 1", ls_done); end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (mc_req === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL store_fetch_cleared: mc_req seen=%0b want 0", seen); end
   endtask

   task automatic test_pf_gating();
      logic seen;
      if_req = 1'b1; if_pc = 32'h500;
      step();
      if_req = 1'b0;
      step();
      step();
      mc_done = 1'b1; mc_rdata = 32'h55555555;
      step();
      mc_done = 1'b0;
      pf_req = 1'b1; pf_addr = 32'h600;
      total++;
      if (if_done !== 1'b1 || if_inst !== 32'h55555555) begin
         bad++;
         $display("FAIL pf_pre_fetch: done=%0b inst=%h want 1/55555555", if_done, if_inst);
      end
      step();
      pf_req = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (mc_req === 1'b1) seen = 1'b1;
         step();
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL pf_hold: early mc_req seen=%0b want 0", seen); end
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h600 || mc_len !== 3'd4 || mc_we !== 1'b0) begin
         bad++;
         $display("FAIL pf_issue: req=%0b addr=%h len=%0d we=%0b want 1/00000600/4/0", mc_req, mc_addr, mc_len, mc_we);
      end
      step();
      mc_done = 1'b1; mc_rdata = 32'hCAFEF00D;
      step();
      mc_done = 1'b0;
      total++;
      if (pf_done !== 1'b1 || pf_data !== 32'hCAFEF00D || if_inst !== 32'h55555555) begin
         bad++;
         $display("FAIL pf_done: done=%0b data=%h inst=%h want 1/cafef00d/55555555", pf_done, pf_data, if_inst);
      end
      pf_req = 1'b1; pf_addr = 32'h700;
      step();
      pf_req = 1'b0;
      step();
      step();
      if_req = 1'b1; if_pc = 32'h800;
      step();
      if_req = 1'b0;
      total++;
      if (mc_req !== 1'b0) begin bad++; $display("FAIL pf_preempt_early: mc_req=%0b want 0", mc_req); end
      step();
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h800) begin
         bad++;
         $display("FAIL pf_preempt_if: req=%0b addr=%h want 1/00000800", mc_req, mc_addr);
      end
      step();
      mc_done = 1'b1; mc_rdata = 32'h88888888;
      step();
      mc_done = 1'b0;
      total++;
      if (if_done !== 1'b1 || if_inst !== 32'h88888888) begin
         bad++;
         $display("FAIL pf_preempt_done: done=%0b inst=%h want 1/88888888", if_done, if_inst);
      end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mc_req === 1'b1) seen = 1'b1;
         step();
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL pf_rehold: early mc_req seen=%0b want 0", seen); end
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h700) begin
         bad++;
         $display("FAIL pf_reissue: req=%0b addr=%h want 1/00000700", mc_req, mc_addr);
      end
      step();
      mc_done = 1'b1; mc_rdata = 32'h77777777;
      step();
      mc_done = 1'b0;
      total++;
      if (pf_done !== 1'b1 || pf_data !== 32'h77777777) begin
         bad++;
         $display("FAIL pf_redone: done=%0b data=%h want 1/77777777", pf_done, pf_data);
      end
   endtask

   task automatic test_rdy_hold();
      if_req = 1'b1; if_pc = 32'hA00;
      step();
      if_req = 1'b0; rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 2) rdy = 1'b1;
         total++;
         if (mc_req !== 1'b0) begin bad++; $display("FAIL rdy_freeze: cycle %0d mc_req=%0b want 0", i, mc_req); end
      end
      step();
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'hA00) begin
         bad++;
         $display("FAIL rdy_resume: req=%0b addr=%h want 1/00000a00", mc_req, mc_addr);
      end
      step();
      mc_done = 1'b1; mc_rdata = 32'hAAAA0000;
      step();
      mc_done = 1'b0;
      total++;
      if (if_done !== 1'b1 || if_inst !== 32'hAAAA0000) begin
         bad++;
         $display("FAIL rdy_done: done=%0b inst=%h want 1/aaaa0000", if_done, if_inst);
      end
   endtask

   task automatic test_overflow();
      logic seen;
      if_req = 1'b1; if_pc = 32'h900;
      step();
      if_req = 1'b0;
      step();
      step();
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000; ls_len = 3'd2;
      step();
      ls_we = 1'b1; ls_addr = 32'h3000; ls_wdata = 32'hFF; ls_len = 3'd4;
      total++;
      if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_first: err=%0b want 0", err_overflow); end
      step();
      ls_req = 1'b0;
      total++;
      if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: err=%0b want 1", err_overflow); end
      mc_done = 1'b1; mc_rdata = 32'h22222222;
      step();
      mc_done = 1'b0;
      step();
      total++;
      if (mc_req !== 1'b1 || mc_addr !== 32'h2000 || mc_we !== 1'b0 || mc_len !== 3'd2) begin
         bad++;
         $display("FAIL ovf_intact: req=%0b addr=%h we=%0b len=%0d want 1/00002000/0/2", mc_req, mc_addr, mc_we, mc_len);
      end
      step();
      mc_done = 1'b1; mc_rdata = 32'hAABBCCDD;
      step();
      mc_done = 1'b0;
      total++;
      if (ls_done !== 1'b1 || ls_rdata !== 32'hAABBCCDD || err_overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_done: done=%0b rdata=%h err=%0b want 1/aabbccdd/1", ls_done, ls_rdata, err_overflow);
      end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (mc_req === 1'b1) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0 || err_overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_dropped: mc_req seen=%0b err=%0b want 0/1", seen, err_overflow);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; rdy = 1'b1; stop_signal = 1'b0;
      if_req = 1'b0; if_pc = 32'h0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_len = 3'd0;
      pf_req = 1'b0; pf_addr = 32'h0;
      mc_done = 1'b0; mc_rdata = 32'h0;
      step();
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_flush_fetch();
      test_flush_store();
      test_pf_gating();
      test_rdy_hold();
      test_overflow();
      test_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
